// File: rtl/uart_pkg.sv
// Shared types, constants and helper functions for the UART receive path.
package uart_pkg;

  // Parity mode selected at elaboration time.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_e;

  // Receiver frame state.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  // Bit positions inside m_axis_tuser.
  localparam int TUSER_PAR_ERR = 0;
  localparam int TUSER_FRM_ERR = 1;

  // Clock cycles per line bit, rounded to nearest.
  function automatic int clks_per_bit(input int clock, input int baud);
    return (clock + baud / 2) / baud;
  endfunction

  // Two-out-of-three majority.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit a transmitter would send for this data (data zero-extended to 9 bits).
  function automatic logic expected_parity(input logic [8:0] data, input parity_e mode);
    logic p;
    case (mode)
      ODD:     p = ~(^data);
      EVEN:    p = ^data;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser, bit-period counter and 3-sample mid-bit majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 43
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rxd_i,
  input  logic restart_i,
  output logic line_o,
  output logic fall_o,
  output logic bit_strobe_o,
  output logic bit_value_o,
  output logic bit_end_o
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(HALF + 1);

  logic [1:0]       sync_q;
  logic             prev_q;
  logic [1:0]       live_q;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             samp0_q, samp0_d;
  logic             samp1_q, samp1_d;
  logic             line_s;

  assign line_s = sync_q[1];

  // Counter wrap/restart, first two vote samples, and edge-detector arming.
  // Arming waits until a real (post-reset) high level has been seen so a
  // line held low through reset does not look like a start edge.
  always_comb begin
    armed_d = armed_q | (live_q[1] & line_s);
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_q == CNT_S0) begin
      samp0_d = line_s;
    end else begin
      samp0_d = samp0_q;
    end
    if (cnt_q == CNT_S1) begin
      samp1_d = line_s;
    end else begin
      samp1_d = samp1_q;
    end
  end

  // Sampler registers; synchroniser presets to the idle-high level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      live_q  <= 2'b00;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      samp0_q <= 1'b1;
      samp1_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      prev_q  <= line_s;
      live_q  <= {live_q[0], 1'b1};
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      samp0_q <= samp0_d;
      samp1_q <= samp1_d;
    end
  end

  assign line_o       = line_s;
  assign fall_o       = armed_q & prev_q & ~line_s;
  assign bit_strobe_o = (cnt_q == CNT_S2);
  assign bit_value_o  = maj3(samp0_q, samp1_q, line_s);
  assign bit_end_o    = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver (5..9 data bits, none/odd/even parity, 1..2 stop bits)
// presenting each frame as one AXI-Stream beat with error flags in tuser.
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int CLOCK          = 20_000_000,
  parameter int BAUD_RATE      = 460_800,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1,
  parameter int PARITY_BITS    = 0
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      rxd,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [1:0]                m_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      overrun,
  output logic                      break_det,
  output logic                      busy
);

  localparam int      CPB       = clks_per_bit(CLOCK, BAUD_RATE);
  localparam parity_e PAR_MODE  = (PARITY_BITS == 1) ? ODD : ((PARITY_BITS == 2) ? EVEN : NONE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  if (CPB < 8) begin : g_chk_cpb
    $error("uart_rx_axis: CLKS_PER_BIT must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_rx_axis: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_rx_axis: STOP_BITS must be 1 or 2");
  end
  if (PARITY_BITS < 0 || PARITY_BITS > 2) begin : g_chk_par
    $error("uart_rx_axis: PARITY_BITS must be 0, 1 or 2");
  end
  if (AXI_DATA_WIDTH < DATA_BITS) begin : g_chk_width
    $error("uart_rx_axis: AXI_DATA_WIDTH narrower than DATA_BITS");
  end

  rx_state_e              state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bit_q, par_bit_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic [AXI_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [1:0]             tuser_q, tuser_d;
  logic                   tvalid_q, tvalid_d;
  logic                   overrun_q, overrun_d;
  logic                   break_q, break_d;
  logic                   busy_q, busy_d;

  logic line_s, fall_s, bit_strobe_s, bit_value_s, bit_end_s;
  logic restart_s, complete_s, frm_now_s, brk_s;

  uart_rx_sampler #(
    .CLKS_PER_BIT(CPB)
  ) u_sampler (
    .clk_i       (aclk),
    .rst_i       (areset),
    .rxd_i       (rxd),
    .restart_i   (restart_s),
    .line_o      (line_s),
    .fall_o      (fall_s),
    .bit_strobe_o(bit_strobe_s),
    .bit_value_o (bit_value_s),
    .bit_end_o   (bit_end_s)
  );

  // Frame FSM: walks start/data/parity/stop on each mid-bit vote.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    restart_s  = 1'b0;
    complete_s = 1'b0;
    frm_now_s  = frm_err_q | ~bit_value_s;
    case (state_q)
      IDLE: begin
        if (fall_s) begin
          state_d   = START;
          restart_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_strobe_s && bit_value_s) begin
          state_d = IDLE;
        end else if (bit_strobe_s) begin
          state_d    = DATA;
          bit_cnt_d  = 4'd0;
          stop_cnt_d = 1'b0;
          shift_d    = '0;
          par_bit_d  = 1'b0;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_strobe_s) begin
          shift_d = {bit_value_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_DATA) begin
            state_d = (PAR_MODE == NONE) ? STOP : PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_strobe_s) begin
          par_bit_d = bit_value_s;
          par_err_d = bit_value_s ^ expected_parity(9'(shift_q), PAR_MODE);
          state_d   = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (bit_strobe_s) begin
          frm_err_d = frm_now_s;
          if (stop_cnt_q == LAST_STOP) begin
            complete_s = 1'b1;
            if (frm_now_s) begin
              state_d   = WAIT_HIGH;
              restart_s = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end
      WAIT_HIGH: begin
        // Any low sample restarts the one-bit-long high qualification.
        if (!line_s) begin
          restart_s = 1'b1;
        end else if (bit_end_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_HIGH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign brk_s = complete_s & (shift_q == '0) & ((PAR_MODE == NONE) | ~par_bit_q) & frm_now_s;

  // Holding register: load on completion unless an unaccepted word is still held.
  always_comb begin
    tdata_d   = tdata_q;
    tuser_d   = tuser_q;
    tvalid_d  = tvalid_q;
    overrun_d = 1'b0;
    break_d   = brk_s;
    busy_d    = (state_d != IDLE);
    if (complete_s && (!tvalid_q || m_axis_tready)) begin
      tdata_d                = AXI_DATA_WIDTH'(shift_q);
      tuser_d                = 2'b00;
      tuser_d[TUSER_PAR_ERR] = par_err_q;
      tuser_d[TUSER_FRM_ERR] = frm_now_s;
      tvalid_d               = 1'b1;
    end else if (complete_s) begin
      overrun_d = 1'b1;
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  // Frame-tracking registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // Output registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tdata_q   <= '0;
      tuser_q   <= 2'b00;
      tvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      tdata_q   <= tdata_d;
      tuser_q   <= tuser_d;
      tvalid_q  <= tvalid_d;
      overrun_q <= overrun_d;
      break_q   <= break_d;
      busy_q    <= busy_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign overrun       = overrun_q;
  assign break_det     = break_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Scoreboard bench: dut_a is 8N1 (defaults), dut_b is 9 data bits, even parity, 2 stop bits.
module tb_uart_rx_axis;

  localparam int CPB = 43;

  logic        aclk;
  logic        areset;
  logic        rxd_a, rxd_b, tready_a, tready_b;
  logic [31:0] tdata_a, tdata_b;
  logic [1:0]  tuser_a, tuser_b;
  logic        tvalid_a, tvalid_b, overrun_a, overrun_b;
  logic        break_a, break_b, busy_a, busy_b;

  uart_rx_axis dut_a (
    .aclk(aclk), .areset(areset), .rxd(rxd_a),
    .m_axis_tdata(tdata_a), .m_axis_tuser(tuser_a), .m_axis_tvalid(tvalid_a),
    .m_axis_tready(tready_a), .overrun(overrun_a), .break_det(break_a), .busy(busy_a)
  );

  uart_rx_axis #(.DATA_BITS(9), .STOP_BITS(2), .PARITY_BITS(2)) dut_b (
    .aclk(aclk), .areset(areset), .rxd(rxd_b),
    .m_axis_tdata(tdata_b), .m_axis_tuser(tuser_b), .m_axis_tvalid(tvalid_b),
    .m_axis_tready(tready_b), .overrun(overrun_b), .break_det(break_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  user;
  } beat_t;

  beat_t exp_a[$];
  beat_t exp_b[$];
  int n_cmp = 0, n_bad = 0, m_cmp = 0, m_bad = 0;
  int ovr_cnt_a = 0, ovr_cnt_b = 0, brk_cnt_a = 0, brk_cnt_b = 0;
  int exp_brk_a = 0, exp_brk_b = 0;
  int cyc = 0, stop_cyc_a = 0, rise_cyc_a = -100000;
  logic tvalid_a_prev = 1'b0;
  bit rand_rdy = 1'b0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, required normal completion");
    $fatal(1, "watchdog expired");
  end

  task automatic mcheck(input string name, input logic [63:0] act, input logic [63:0] req);
    m_cmp++;
    if (act !== req) begin
      m_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare every accepted beat with the head of the matching queue.
  always @(negedge aclk) begin : mon
    beat_t ba;
    beat_t bb;
    if (!areset && tvalid_a && tready_a) begin
      if (exp_a.size() == 0) begin
        m_cmp++; m_bad++;
        $display("FAIL a_unexpected_beat: actual tdata=%0h tuser=%0b, required no beat", tdata_a, tuser_a);
      end else begin
        ba = exp_a.pop_front();
        mcheck("a_tdata", 64'(tdata_a), 64'(ba.data));
        mcheck("a_tuser", 64'(tuser_a), 64'(ba.user));
      end
    end
    if (!areset && tvalid_b && tready_b) begin
      if (exp_b.size() == 0) begin
        m_cmp++; m_bad++;
        $display("FAIL b_unexpected_beat: actual tdata=%0h tuser=%0b, required no beat", tdata_b, tuser_b);
      end else begin
        bb = exp_b.pop_front();
        mcheck("b_tdata", 64'(tdata_b), 64'(bb.data));
        mcheck("b_tuser", 64'(tuser_b), 64'(bb.user));
      end
    end
    if (overrun_a) ovr_cnt_a++;
    if (overrun_b) ovr_cnt_b++;
    if (break_a) brk_cnt_a++;
    if (break_b) brk_cnt_b++;
    if (tvalid_a && !tvalid_a_prev) rise_cyc_a = cyc;
    tvalid_a_prev = tvalid_a;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
      if (rand_rdy) begin
        tready_a = 1'($urandom_range(0, 1));
        tready_b = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic set_rxd(input bit to_b, input logic v);
    if (to_b) rxd_b = v;
    else      rxd_a = v;
  endtask

  // Serialise one frame; the reference beat is derived from what goes on the wire.
  task automatic send(input bit to_b, input logic [8:0] data, input bit flip_par,
                      input logic [1:0] stop_low, input int glitch_bit, input bit expect_beat);
    logic  bits[$];
    int    nd, ns;
    logic  par, frm;
    beat_t b;
    nd = to_b ? 9 : 8;
    ns = to_b ? 2 : 1;
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) bits.push_back(data[i]);
    par = 1'b0;
    if (to_b) begin
      par = (^data) ^ flip_par;
      bits.push_back(par);
    end
    for (int i = 0; i < ns; i++) bits.push_back(~stop_low[i]);
    frm    = to_b ? (|stop_low) : stop_low[0];
    b.data = to_b ? {23'd0, data} : {24'd0, data[7:0]};
    b.user = {frm, to_b & flip_par};
    if (expect_beat) begin
      if (to_b) exp_b.push_back(b);
      else      exp_a.push_back(b);
    end
    if (frm && b.data == 32'd0 && !par) begin
      if (to_b) exp_brk_b++;
      else      exp_brk_a++;
    end
    for (int i = 0; i < bits.size(); i++) begin
      if (!to_b && i == 9) stop_cyc_a = cyc;
      for (int c = 0; c < CPB; c++) begin
        set_rxd(to_b, (i == glitch_bit && c == 23) ? ~bits[i] : bits[i]);
        tick(1);
      end
    end
    set_rxd(to_b, 1'b1);
  endtask

  initial begin : stim
    int ovr_base;
    logic [8:0] d;
    logic [1:0] sl;
    areset = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1; tready_a = 1'b1; tready_b = 1'b1;
    tick(5);
    check("a_reset_outputs", 64'({tdata_a, tuser_a, tvalid_a, overrun_a, break_a, busy_a}), 64'd0);
    check("b_reset_outputs", 64'({tdata_b, tuser_b, tvalid_b, overrun_b, break_b, busy_b}), 64'd0);
    areset = 1'b0;
    tick(100);

    // Basic 8N1 word and completion latency.
    send(1'b0, 9'h0A5, 1'b0, 2'b00, -1, 1'b1);
    tick(60);
    check("a_latency_in_window", 64'((rise_cyc_a - stop_cyc_a >= 22) && (rise_cyc_a - stop_cyc_a <= 30)), 64'd1);
    check("a_busy_after_frame", 64'(busy_a), 64'd0);
    check("a_drained_basic", 64'(exp_a.size()), 64'd0);

    // 9E2 good parity then flipped parity.
    send(1'b1, 9'h1F3, 1'b0, 2'b00, -1, 1'b1);
    tick(100);
    send(1'b1, 9'h1F3, 1'b1, 2'b00, -1, 1'b1);
    tick(100);
    check("b_drained_parity", 64'(exp_b.size()), 64'd0);

    // Framing error, then break, then line held low.
    send(1'b0, 9'h03C, 1'b0, 2'b01, -1, 1'b1);
    tick(5);
    check("a_busy_wait_high", 64'(busy_a), 64'd1);
    tick(100);
    send(1'b0, 9'h000, 1'b0, 2'b01, -1, 1'b1);
    rxd_a = 1'b0;
    tick(300);
    check("a_busy_held_low", 64'(busy_a), 64'd1);
    rxd_a = 1'b1;
    tick(30);
    rxd_a = 1'b0;
    tick(100);
    check("a_busy_short_high", 64'(busy_a), 64'd1);
    rxd_a = 1'b1;
    tick(60);
    check("a_busy_released", 64'(busy_a), 64'd0);
    check("a_break_pulses", 64'(brk_cnt_a), 64'(exp_brk_a));
    check("a_drained_break", 64'(exp_a.size()), 64'd0);

    // False start and a single-cycle data glitch.
    rxd_a = 1'b0;
    tick(10);
    check("a_busy_false_start", 64'(busy_a), 64'd1);
    rxd_a = 1'b1;
    tick(60);
    check("a_busy_after_glitch", 64'(busy_a), 64'd0);
    send(1'b0, 9'h05A, 1'b0, 2'b00, 4, 1'b1);
    tick(60);
    check("a_drained_glitch", 64'(exp_a.size()), 64'd0);

    // Backpressure and overrun.
    tready_a = 1'b0;
    ovr_base = ovr_cnt_a;
    send(1'b0, 9'h011, 1'b0, 2'b00, -1, 1'b1);
    tick(50);
    send(1'b0, 9'h022, 1'b0, 2'b00, -1, 1'b0);
    tick(50);
    check("a_overrun_cycles", 64'(ovr_cnt_a - ovr_base), 64'd1);
    check("a_held_word", 64'({tvalid_a, tdata_a}), 64'({1'b1, 32'h11}));
    tready_a = 1'b1;
    tick(10);
    check("a_valid_after_accept", 64'(tvalid_a), 64'd0);
    check("a_drained_overrun", 64'(exp_a.size()), 64'd0);

    // Reset in the middle of 0x55, released with rxd low.
    rxd_a = 1'b0; tick(CPB);
    rxd_a = 1'b1; tick(CPB);
    rxd_a = 1'b0; tick(CPB);
    rxd_a = 1'b1; tick(CPB);
    rxd_a = 1'b0; tick(20);
    check("a_busy_mid_frame", 64'(busy_a), 64'd1);
    areset = 1'b1;
    #1;
    check("a_outputs_in_reset", 64'({tdata_a, tuser_a, tvalid_a, overrun_a, break_a, busy_a}), 64'd0);
    tick(20);
    areset = 1'b0;
    tick(200);
    check("a_no_start_low_after_reset", 64'({busy_a, tvalid_a}), 64'd0);
    rxd_a = 1'b1;
    tick(100);
    send(1'b0, 9'h066, 1'b0, 2'b00, -1, 1'b1);
    tick(60);
    check("a_drained_reset", 64'(exp_a.size()), 64'd0);

    // Randomised traffic with random ready on both receivers.
    rand_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      send(1'b0, 9'($urandom_range(0, 255)), 1'b0, 2'b00,
           ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1, 1'b1);
      tick(2 * CPB + int'($urandom_range(0, 30)));
    end
    for (int k = 0; k < 12; k++) begin
      d  = (k % 4 == 0) ? 9'd0 : 9'($urandom_range(0, 511));
      sl = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send(1'b1, d, 1'($urandom_range(0, 1)), sl, -1, 1'b1);
      tick(2 * CPB + int'($urandom_range(0, 30)));
    end
    rand_rdy = 1'b0;
    tready_a = 1'b1;
    tready_b = 1'b1;
    tick(50);
    check("a_drained_random", 64'(exp_a.size()), 64'd0);
    check("b_drained_random", 64'(exp_b.size()), 64'd0);
    check("a_break_total", 64'(brk_cnt_a), 64'(exp_brk_a));
    check("b_break_total", 64'(brk_cnt_b), 64'(exp_brk_b));
    check("a_overrun_total", 64'(ovr_cnt_a), 64'd1);
    check("b_overrun_total", 64'(ovr_cnt_b), 64'd0);

    n_cmp += m_cmp;
    n_bad += m_bad;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
